// File: rtl/capture_buffer_ctrl_pkg.sv
// Shared types and constants for the capture buffer controller.
package capture_buffer_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    // Capture modes, selected by i_mode when a capture is armed
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CIRC   = 1'b1;

endpackage : capture_buffer_ctrl_pkg

// File: rtl/capture_buffer_ctrl_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// The read register holds its value when no read is requested, which gives
// the controller's o_data its "hold last value" behaviour for free.
module capture_ram #(
    parameter int NB_DATA = 14,
    parameter int NB_ADDR = 11
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    // Sample write port
    // NOTE: the array itself is never reset, so it maps onto block RAM;
    // only the output register below is cleared.
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, one cycle latency, holds when not reading
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule : capture_ram

// File: rtl/capture_buffer_ctrl.sv
// Capture buffer controller: records a burst of samples (single-shot or
// circular) into capture_ram, then plays them back oldest-first on request.
module capture_buffer_ctrl
    import capture_buffer_ctrl_pkg::*;
#(
    parameter int NB_DATA = 14,
    parameter int NB_ADDR = 11
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_mode,
    input  logic               i_read_req,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_data_valid,
    output logic               o_full,
    output logic               o_busy,
    output logic [NB_ADDR:0]   o_count
);

    localparam int               DEPTH     = 2 ** NB_ADDR;
    localparam logic [NB_ADDR:0] COUNT_MAX = (NB_ADDR + 1)'(DEPTH);
    localparam logic [NB_ADDR:0] COUNT_ONE = (NB_ADDR + 1)'(1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(DEPTH - 1);

    state_t             state;
    logic               mode;
    logic [NB_ADDR-1:0] wr_ptr;
    logic [NB_ADDR-1:0] rd_ptr;
    logic [NB_ADDR:0]   count;

    logic               wr_en;
    logic               rd_en;
    logic [NB_ADDR-1:0] wr_ptr_next;
    logic [NB_ADDR:0]   count_after_wr;
    logic [NB_ADDR-1:0] full_rd_ptr;
    logic               last_single_wr;

    // Write/read strobes and the values the FSM commits this cycle
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        wr_ptr_next    = wr_ptr;
        count_after_wr = count;
        full_rd_ptr    = '0;
        last_single_wr = 1'b0;

        wr_en = (state == ST_CAPTURE) && i_valid;
        rd_en = ((state == ST_FULL) || (state == ST_READOUT)) && i_read_req;

        if (wr_en) begin
            wr_ptr_next = wr_ptr + 1'b1;
            if (count != COUNT_MAX) begin
                count_after_wr = count + 1'b1;
            end
        end

        // A wrapped circular buffer starts playback at the oldest sample,
        // which is the slot the write pointer will overwrite next.
        if ((mode == MODE_CIRC) && (count_after_wr == COUNT_MAX)) begin
            full_rd_ptr = wr_ptr_next;
        end

        last_single_wr = (mode == MODE_SINGLE) && wr_en && (wr_ptr == LAST_ADDR);
    end

    // Controller FSM with registered status outputs
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state        <= ST_IDLE;
            mode         <= MODE_SINGLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_full       <= 1'b0;
            o_busy       <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= rd_en;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state  <= ST_CAPTURE;
                        mode   <= i_mode;
                        wr_ptr <= '0;
                        count  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    wr_ptr <= wr_ptr_next;
                    count  <= count_after_wr;
                    if (last_single_wr || (i_stop && (count_after_wr != '0))) begin
                        state  <= ST_FULL;
                        rd_ptr <= full_rd_ptr;
                        o_full <= 1'b1;
                        o_busy <= 1'b0;
                    end else if (i_stop) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                ST_FULL, ST_READOUT: begin
                    if (rd_en) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                        o_full <= 1'b0;
                        if (count == COUNT_ONE) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state  <= ST_READOUT;
                            o_busy <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_full <= 1'b0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_count = count;

    capture_ram #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_ptr),
        .i_wr_data (i_data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_ptr),
        .o_rd_data (o_data)
    );

endmodule : capture_buffer_ctrl

// File: tb/tb_capture_buffer_ctrl.sv
// Directed testbench for capture_buffer_ctrl with an 8-entry buffer.
module tb_capture_buffer_ctrl;

    localparam int NB_DATA = 14;
    localparam int NB_ADDR = 3;

    logic               clock = 1'b0;
    logic               i_reset;
    logic [NB_DATA-1:0] i_data;
    logic               i_valid;
    logic               i_start;
    logic               i_stop;
    logic               i_mode;
    logic               i_read_req;
    logic [NB_DATA-1:0] o_data;
    logic               o_data_valid;
    logic               o_full;
    logic               o_busy;
    logic [NB_ADDR:0]   o_count;

    int vectors     = 0;
    int miscompares = 0;

    capture_buffer_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_mode       (i_mode),
        .i_read_req   (i_read_req),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_full       (o_full),
        .o_busy       (o_busy),
        .o_count      (o_count)
    );

    always #5 clock = ~clock;

    // Advance one rising edge and settle before sampling outputs
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input logic mode);
        i_mode  = mode;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic push(input int value, input logic stop);
        i_valid = 1'b1;
        i_data  = NB_DATA'(value);
        i_stop  = stop;
        tick();
        i_valid = 1'b0;
        i_stop  = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        #3;
        vectors++; if (o_data !== '0)    begin miscompares++; $display("FAIL reset_data: got %0d expected 0", o_data); end
        vectors++; if (o_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_data_valid); end
        vectors++; if (o_full !== 1'b0)  begin miscompares++; $display("FAIL reset_full: got %b expected 0", o_full); end
        vectors++; if (o_busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        vectors++; if (o_count !== '0)   begin miscompares++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        @(negedge clock);
        i_reset = 1'b1;
    endtask

    task automatic test_single_shot();
        arm(1'b0);
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL ss_armed_busy: got %b expected 1", o_busy); end
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL ss_armed_count: got %0d expected 0", o_count); end
        for (int k = 1; k <= 8; k++) begin
            push(k, 1'b0);
            vectors++; if (o_count !== 4'(k)) begin miscompares++; $display("FAIL ss_count[%0d]: got %0d expected %0d", k, o_count, k); end
        end
        vectors++; if (o_full !== 1'b1) begin miscompares++; $display("FAIL ss_full: got %b expected 1", o_full); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL ss_full_busy: got %b expected 0", o_busy); end
        // Extra sample after FULL must be ignored
        push(99, 1'b0);
        vectors++; if (o_count !== 4'd8) begin miscompares++; $display("FAIL ss_extra_count: got %0d expected 8", o_count); end
        i_read_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++; if (o_data_valid !== 1'b1) begin miscompares++; $display("FAIL ss_rd_valid[%0d]: got %b expected 1", k, o_data_valid); end
            vectors++; if (o_data !== NB_DATA'(k)) begin miscompares++; $display("FAIL ss_rd_data[%0d]: got %0d expected %0d", k, o_data, k); end
            vectors++; if (o_count !== 4'(8 - k)) begin miscompares++; $display("FAIL ss_rd_count[%0d]: got %0d expected %0d", k, o_count, 8 - k); end
            vectors++; if (o_busy !== (k < 8)) begin miscompares++; $display("FAIL ss_rd_busy[%0d]: got %b expected %b", k, o_busy, (k < 8)); end
        end
        i_read_req = 1'b0;
        tick();
        vectors++; if (o_data_valid !== 1'b0) begin miscompares++; $display("FAIL ss_done_valid: got %b expected 0", o_data_valid); end
        vectors++; if (o_data !== NB_DATA'(8)) begin miscompares++; $display("FAIL ss_hold_data: got %0d expected 8", o_data); end
        vectors++; if (o_full !== 1'b0) begin miscompares++; $display("FAIL ss_done_full: got %b expected 0", o_full); end
    endtask

    task automatic test_circular();
        arm(1'b1);
        for (int k = 1; k <= 11; k++) begin
            push(k, 1'b0);
            vectors++; if (o_count !== 4'((k > 8) ? 8 : k)) begin miscompares++; $display("FAIL circ_count[%0d]: got %0d expected %0d", k, o_count, (k > 8) ? 8 : k); end
        end
        vectors++; if (o_full !== 1'b0 || o_busy !== 1'b1) begin miscompares++; $display("FAIL circ_still_capturing: got full=%b busy=%b expected full=0 busy=1", o_full, o_busy); end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        vectors++; if (o_full !== 1'b1) begin miscompares++; $display("FAIL circ_full: got %b expected 1", o_full); end
        vectors++; if (o_count !== 4'd8) begin miscompares++; $display("FAIL circ_stop_count: got %0d expected 8", o_count); end
        i_read_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++; if (o_data_valid !== 1'b1 || o_data !== NB_DATA'(k + 3)) begin miscompares++; $display("FAIL circ_rd[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", k, o_data_valid, o_data, k + 3); end
        end
        i_read_req = 1'b0;
        tick();
        vectors++; if (o_busy !== 1'b0 || o_count !== 4'd0) begin miscompares++; $display("FAIL circ_idle: got busy=%b count=%0d expected busy=0 count=0", o_busy, o_count); end
    endtask

    task automatic test_early_stop();
        arm(1'b0);
        for (int k = 1; k <= 3; k++) push(k, 1'b0);
        push(4, 1'b1);
        vectors++; if (o_full !== 1'b1) begin miscompares++; $display("FAIL early_full: got %b expected 1", o_full); end
        vectors++; if (o_count !== 4'd4) begin miscompares++; $display("FAIL early_count: got %0d expected 4", o_count); end
        i_read_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++; if (o_data_valid !== 1'b1 || o_data !== NB_DATA'(k)) begin miscompares++; $display("FAIL early_rd[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", k, o_data_valid, o_data, k); end
        end
        i_read_req = 1'b0;
        tick();
        vectors++; if (o_busy !== 1'b0 || o_count !== 4'd0) begin miscompares++; $display("FAIL early_idle: got busy=%b count=%0d expected busy=0 count=0", o_busy, o_count); end
    endtask

    task automatic test_empty_stop();
        arm(1'b0);
        vectors++; if (o_full !== 1'b0) begin miscompares++; $display("FAIL empty_armed_full: got %b expected 0", o_full); end
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        vectors++; if (o_full !== 1'b0) begin miscompares++; $display("FAIL empty_full: got %b expected 0", o_full); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy: got %b expected 0", o_busy); end
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL empty_count: got %0d expected 0", o_count); end
    endtask

    task automatic test_ignored();
        arm(1'b0);
        push(5, 1'b0);
        push(6, 1'b1);
        // i_start (with circular mode) and a stray sample while FULL
        i_start = 1'b1;
        i_mode  = 1'b1;
        i_valid = 1'b1;
        i_data  = NB_DATA'(77);
        tick();
        i_start = 1'b0;
        i_valid = 1'b0;
        vectors++; if (o_full !== 1'b1 || o_busy !== 1'b0) begin miscompares++; $display("FAIL ign_start_state: got full=%b busy=%b expected full=1 busy=0", o_full, o_busy); end
        vectors++; if (o_count !== 4'd2) begin miscompares++; $display("FAIL ign_start_count: got %0d expected 2", o_count); end
        i_read_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (o_data_valid !== 1'b1 || o_data !== NB_DATA'(5 + k)) begin miscompares++; $display("FAIL ign_rd[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", k, o_data_valid, o_data, 5 + k); end
        end
        // Now IDLE: read request must do nothing
        tick();
        vectors++; if (o_data_valid !== 1'b0) begin miscompares++; $display("FAIL ign_idle_valid: got %b expected 0", o_data_valid); end
        vectors++; if (o_data !== NB_DATA'(6)) begin miscompares++; $display("FAIL ign_idle_data: got %0d expected 6", o_data); end
        vectors++; if (o_busy !== 1'b0 || o_full !== 1'b0 || o_count !== 4'd0) begin miscompares++; $display("FAIL ign_idle_state: got busy=%b full=%b count=%0d expected 0/0/0", o_busy, o_full, o_count); end
        i_read_req = 1'b0;
    endtask

    task automatic test_reset_readout();
        arm(1'b0);
        for (int k = 0; k < 8; k++) push(20 + k, 1'b0);
        i_read_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (o_data !== NB_DATA'(20 + k)) begin miscompares++; $display("FAIL rst_pre_rd[%0d]: got %0d expected %0d", k, o_data, 20 + k); end
        end
        #2;
        i_reset = 1'b0;
        #1;
        vectors++; if (o_data !== '0 || o_data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_data: got data=%0d valid=%b expected 0/0", o_data, o_data_valid); end
        vectors++; if (o_full !== 1'b0 || o_busy !== 1'b0 || o_count !== '0) begin miscompares++; $display("FAIL rst_mid_state: got full=%b busy=%b count=%0d expected 0/0/0", o_full, o_busy, o_count); end
        i_read_req = 1'b0;
        @(negedge clock);
        i_reset = 1'b1;
        arm(1'b0);
        push(40, 1'b0);
        push(41, 1'b1);
        vectors++; if (o_full !== 1'b1 || o_count !== 4'd2) begin miscompares++; $display("FAIL rst_new_full: got full=%b count=%0d expected 1/2", o_full, o_count); end
        i_read_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++; if (o_data_valid !== 1'b1 || o_data !== NB_DATA'(40 + k)) begin miscompares++; $display("FAIL rst_new_rd[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", k, o_data_valid, o_data, 40 + k); end
        end
        i_read_req = 1'b0;
        tick();
    endtask

    initial begin
        i_reset    = 1'b1;
        i_data     = '0;
        i_valid    = 1'b0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_mode     = 1'b0;
        i_read_req = 1'b0;
        #2;
        test_reset();
        test_single_shot();
        test_circular();
        test_early_stop();
        test_empty_stop();
        test_ignored();
        test_reset_readout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_capture_buffer_ctrl

// File: doc/capture_buffer_ctrl.md
CAPTURE_BUFFER_CTRL -- requirements
Module: capture_buffer_ctrl

Interface
REQ-001 Parameter: NB_DATA, default 14, sample width in bits.
REQ-002 Parameter: NB_ADDR, default 11, address width; DEPTH = 2**NB_ADDR, derived internally, not a parameter.
REQ-003 Port: clock  in  1  single clock; all logic rising-edge.
REQ-004 Port: i_reset  in  1  reset, asynchronous, active-low.
REQ-005 Port: i_data  in  NB_DATA  sample to capture.
REQ-006 Port: i_valid  in  1  sample strobe, one sample per high cycle.
REQ-007 Port: i_start  in  1  arm/begin capture pulse.
REQ-008 Port: i_stop  in  1  end capture pulse.
REQ-009 Port: i_mode  in  1  0 = single-shot, 1 = circular; sampled on i_start acceptance only.
REQ-010 Port: i_read_req  in  1  request next stored sample.
REQ-011 Port: o_data  out  NB_DATA  readout sample.
REQ-012 Port: o_data_valid  out  1  o_data valid this cycle.
REQ-013 Port: o_full  out  1  high in FULL state (drives red LED).
REQ-014 Port: o_busy  out  1  high in CAPTURE or READOUT.
REQ-015 Port: o_count  out  NB_ADDR+1  samples stored, or remaining during READOUT.

Function
REQ-016 FSM states: IDLE, CAPTURE, FULL, READOUT.
REQ-017 IDLE: i_start -> CAPTURE; write pointer and o_count cleared to 0; mode latched.
REQ-018 CAPTURE: each i_valid writes i_data at write pointer; pointer +1; o_count +1, saturating at DEPTH.
REQ-019 Single-shot: write at address DEPTH-1 -> FULL next cycle; further i_valid ignored.
REQ-020 Circular: pointer wraps DEPTH-1 -> 0, overwriting oldest; stays in CAPTURE until i_stop.
REQ-021 i_stop in CAPTURE -> FULL if o_count (including same-cycle write) > 0, else IDLE.
REQ-022 i_valid coincident with i_stop: sample written before transition.
REQ-023 i_start ignored outside IDLE; i_stop ignored outside CAPTURE; i_read_req ignored outside FULL/READOUT.
REQ-024 Entering FULL: read pointer = write pointer if circular and o_count == DEPTH (oldest sample), else 0.
REQ-025 FULL: i_read_req -> READOUT and counts as first read.
REQ-026 Each accepted read: o_data = memory[read pointer] one cycle later with o_data_valid high one cycle; read pointer +1 with wrap; o_count -1.
REQ-027 Read latency exactly 1 cycle; back-to-back i_read_req yields back-to-back valid data.
REQ-028 Read accepted with o_count == 1 -> IDLE next cycle; final o_data_valid still issued.
REQ-029 o_data holds last value when o_data_valid low.

Reset
REQ-030 i_reset low: state IDLE, pointers 0, o_count 0, o_full 0, o_busy 0, o_data_valid 0, o_data 0, asynchronously.
REQ-031 Reset mid-CAPTURE or mid-READOUT aborts; memory contents undefined, not cleared.
REQ-032 Reset deassertion synchronised externally; block needs no internal synchroniser.

Structure
REQ-033 Shared package/header holds state encodings and mode constants (MODE_SINGLE = 0, MODE_CIRC = 1).
REQ-034 One sub-module capture_ram: simple dual-port, one write and one registered-read port, NB_DATA x DEPTH.
REQ-035 FSM, pointers and counters reside in capture_buffer_ctrl.

Verification (NB_ADDR = 3, DEPTH = 8)
REQ-036 Single-shot: i_start, 8 valid samples 1..8 -> o_full = 1, o_count = 8; 8 reads -> data 1..8, then IDLE.
REQ-037 Circular: i_start, samples 1..11, i_stop -> o_count = 8; reads -> 4..11 in order.
REQ-038 Early stop: single-shot, samples 1..3, i_stop with sample 4 in the same cycle -> o_count = 4, reads -> 1..4.
REQ-039 Empty stop: i_start then i_stop with no valid -> IDLE, o_full never asserted.
REQ-040 Reset mid-READOUT after 2 reads -> all outputs 0 immediately; new capture works.
REQ-041 Ignored inputs: i_start in FULL and i_read_req in IDLE -> no state, pointer or count change.
